serv_sleep_ctrl: RTL and testbench
==================================

# serv_sleep_ctrl

Parametrised sleep/wake controller for SERV-based SoCs. Drains the Wishbone bus before sleeping, gates the core clock through a registered enable, and wakes on the core wakeup request or any of NUM_WAKE maskable interrupt lines. It adds a settle delay and reports the wake cause. It sits between the core's `o_sleep_req`/`o_wakeup_req` and the SoC clock-gate cell, with the timer domain left ungated.

## Interface
- NUM_WAKE, 1: number of external wake/interrupt lines.
- SETTLE, 2: extra cycles held in WAKE before the clock is re-enabled (0 allowed).
- DRAIN_MAX, 16: maximum cycles spent waiting for bus idle before abort; 0 means wait forever.

- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sleep_req  in  1  core requests sleep (level, sampled every cycle).
- i_wakeup_req  in  1  core wakeup request (cause bit 0).
- i_irq  in  NUM_WAKE  external wake lines, level.
- i_wake_mask  in  NUM_WAKE  1 = line may wake the core.
- i_bus_busy  in  1  Wishbone cycle in flight (cyc & !ack).
- o_clk_en  out  1  registered enable to the clock-gate cell.
- o_sleep  out  1  high in SLEEP and WAKE.
- o_wake_src  out  NUM_WAKE+1  latched cause: bit 0 is wakeup_req, bits 1.. are masked irqs.
- o_wake_vld  out  1  one-cycle pulse on return to RUN.
- o_drain_err  out  1  one-cycle pulse on drain timeout.
- o_sleep_cycles  out  32  sleep-cycle statistic (see Configuration).

## Operation
- wake_any = i_wakeup_req | |(i_irq & i_wake_mask).
- Reset values: state RUN, o_clk_en=1, o_sleep=0, o_wake_src=0, o_wake_vld=0, o_drain_err=0, all counters 0.
- RUN: i_sleep_req & !wake_any goes to DRAIN and loads the drain counter with 0. If sleep and wake arrive in the same cycle, wake wins and the state stays RUN.
- DRAIN (o_clk_en still 1):
  - wake_any: return to RUN, no o_wake_vld.
  - else !i_bus_busy: go to SLEEP.
  - else DRAIN_MAX≠0 and drain counter == DRAIN_MAX-1: return to RUN and pulse o_drain_err.
  - else increment the drain counter.
- SLEEP: o_clk_en=0, o_sleep=1. On wake_any, latch o_wake_src = {i_irq & i_wake_mask, i_wakeup_req}, load the settle counter with SETTLE, and go to WAKE.
- WAKE: o_clk_en=0.
  - Counter == 0: go to RUN, set o_clk_en=1, pulse o_wake_vld.
  - Otherwise decrement.
  - Wake inputs are ignored in this state.
- o_wake_src holds its value until the next wake latch or reset.
- Counter widths: settle uses $clog2(SETTLE+1), drain uses $clog2(DRAIN_MAX+1); both have a minimum width of 1.

## Timing
- All outputs are registered and update on the same edge as the state.
- Sleep entry: request at cycle n with the bus idle gives DRAIN at n+1 and SLEEP at n+2, with o_clk_en=0 from n+2. Each busy cycle adds one cycle.
- Wake exit: wake_any at cycle m in SLEEP gives WAKE at m+1. RUN, o_clk_en=1 and o_wake_vld all occur at m+SETTLE+2.
- Reset in any state: RUN on the next edge with o_clk_en=1. Pending pulses and counters clear; o_wake_src clears.
- A still-asserted i_sleep_req in the cycle after RUN is re-entered starts a new DRAIN. The core must drop the request once woken.

## Configuration
- SERV_SLEEP_CTRL_STATS_EN defined:
  - o_sleep_cycles increments once per cycle in SLEEP or WAKE.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Not defined: o_sleep_cycles is tied to 0 and no counter flops are built. The port list is identical in both builds.

## Structure
- Package serv_sleep_pkg holds:
  - typedef enum state_t {RUN, DRAIN, SLEEP, WAKE};
  - localparam WAKE_SRC_CORE = 0 (cause bit index).
- Sub-module serv_sleep_cnt is a parametrised-width load/step/zero-detect counter. It is instantiated twice: settle (down-count) and drain (up-count with compare).

## Test plan
- SETTLE=2: sleep_req with bus idle at n → o_clk_en=0 at n+2. Then irq[1] with mask=1 at m → o_clk_en=1, o_wake_vld=1, o_wake_src=3'b100 at m+4.
- Sleep_req and wakeup_req asserted in the same cycle → state stays RUN, o_clk_en never drops.
- DRAIN_MAX=4 with i_bus_busy held high → o_drain_err pulses 5 cycles after the request, state returns to RUN, o_clk_en stays 1 throughout.
- Masked irq (mask=0) asserted in SLEEP → no wake. Unmasking it afterwards → wake and o_wake_src latched.
- i_rst during WAKE → RUN next edge, o_clk_en=1, o_wake_src=0, no o_wake_vld.
- STATS build: sleep for 10 SLEEP+WAKE cycles → o_sleep_cycles=10. Preloaded to 32'hFFFF_FFFF, the counter holds its value.

Source files
------------

// File: rtl/serv_sleep_ctrl_pkg.sv
// Shared types and constants for the SERV sleep/wake controller.
package serv_sleep_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  localparam int WAKE_SRC_CORE = 0;

endpackage

// File: rtl/serv_sleep_ctrl_if.sv
// Core/SoC-facing signal bundle of the sleep controller; slave = controller side.
interface serv_sleep_ctrl_if #(
  parameter int NUM_WAKE = 1
);
  logic                i_sleep_req;
  logic                i_wakeup_req;
  logic [NUM_WAKE-1:0] i_irq;
  logic [NUM_WAKE-1:0] i_wake_mask;
  logic                i_bus_busy;
  logic                o_clk_en;
  logic                o_sleep;
  logic [NUM_WAKE:0]   o_wake_src;
  logic                o_wake_vld;
  logic                o_drain_err;
  logic [31:0]         o_sleep_cycles;

  modport slave (
    input  i_sleep_req, i_wakeup_req, i_irq, i_wake_mask, i_bus_busy,
    output o_clk_en, o_sleep, o_wake_src, o_wake_vld, o_drain_err, o_sleep_cycles
  );

  modport master (
    output i_sleep_req, i_wakeup_req, i_irq, i_wake_mask, i_bus_busy,
    input  o_clk_en, o_sleep, o_wake_src, o_wake_vld, o_drain_err, o_sleep_cycles
  );
endinterface

// File: rtl/serv_sleep_ctrl_cnt.sv
// Load/step counter with a compare against a fixed value (MATCH=0 gives zero detect).
module serv_sleep_cnt #(
  parameter int         W     = 1,
  parameter bit         UP    = 1'b0,
  parameter logic [W-1:0] MATCH = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic         hit
);
  logic [W-1:0] cnt_r;

  // Load has priority over stepping; direction fixed by UP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (step) begin
      cnt_r <= UP ? (cnt_r + W'(1)) : (cnt_r - W'(1));
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == MATCH);
endmodule

// File: rtl/serv_sleep_ctrl.sv
// SERV sleep/wake controller: bus drain, registered clock enable, settle delay, wake cause.
// Optional sleep-cycle statistic built when SERV_SLEEP_CTRL_STATS_EN is defined.
module serv_sleep_ctrl
  import serv_sleep_pkg::*;
#(
  parameter int NUM_WAKE  = 1,
  parameter int SETTLE    = 2,
  parameter int DRAIN_MAX = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  serv_sleep_ctrl_if.slave bus
);
  localparam int SETTLE_W = (SETTLE    == 0) ? 1 : $clog2(SETTLE + 1);
  localparam int DRAIN_W  = (DRAIN_MAX == 0) ? 1 : $clog2(DRAIN_MAX + 1);
  localparam bit DRAIN_LIMITED = (DRAIN_MAX != 0);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'((DRAIN_MAX == 0) ? 0 : DRAIN_MAX - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

  state_t            state_r;
  logic              clk_en_r;
  logic              sleep_r;
  logic              wake_vld_r;
  logic              drain_err_r;
  logic [NUM_WAKE:0] wake_src_r;

  logic wake_any_s;
  logic drain_match_s;
  logic drain_hit_s;
  logic drain_load_s;
  logic drain_step_s;
  logic settle_zero_s;
  logic settle_load_s;
  logic settle_step_s;

  assign wake_any_s  = bus.i_wakeup_req | (|(bus.i_irq & bus.i_wake_mask));
  assign drain_hit_s = DRAIN_LIMITED & drain_match_s;

  // Counter control decoded from the current state and inputs.
  always_comb begin
    drain_load_s  = 1'b0;
    drain_step_s  = 1'b0;
    settle_load_s = 1'b0;
    settle_step_s = 1'b0;
    case (state_r)
      RUN: begin
        drain_load_s = bus.i_sleep_req & ~wake_any_s;
      end
      DRAIN: begin
        drain_step_s = DRAIN_LIMITED & ~wake_any_s & bus.i_bus_busy & ~drain_match_s;
      end
      SLEEP: begin
        settle_load_s = wake_any_s;
      end
      WAKE: begin
        settle_step_s = ~settle_zero_s;
      end
      default: begin
        drain_load_s = 1'b0;
      end
    endcase
  end

  serv_sleep_cnt #(
    .W     (DRAIN_W),
    .UP    (1'b1),
    .MATCH (DRAIN_LAST)
  ) u_drain_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (drain_load_s),
    .load_val ({DRAIN_W{1'b0}}),
    .step     (drain_step_s),
    .hit      (drain_match_s)
  );

  serv_sleep_cnt #(
    .W     (SETTLE_W),
    .UP    (1'b0),
    .MATCH ({SETTLE_W{1'b0}})
  ) u_settle_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (settle_load_s),
    .load_val (SETTLE_VAL),
    .step     (settle_step_s),
    .hit      (settle_zero_s)
  );

  // Main FSM; every output is registered and changes with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= RUN;
      clk_en_r    <= 1'b1;
      sleep_r     <= 1'b0;
      wake_vld_r  <= 1'b0;
      drain_err_r <= 1'b0;
      wake_src_r  <= '0;
    end else begin
      wake_vld_r  <= 1'b0;
      drain_err_r <= 1'b0;
      case (state_r)
        RUN: begin
          // A simultaneous wake request cancels the sleep request.
          if (bus.i_sleep_req && !wake_any_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (wake_any_s) begin
            state_r <= RUN;
          end else if (!bus.i_bus_busy) begin
            state_r  <= SLEEP;
            clk_en_r <= 1'b0;
            sleep_r  <= 1'b1;
          end else if (drain_hit_s) begin
            state_r     <= RUN;
            drain_err_r <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        SLEEP: begin
          if (wake_any_s) begin
            state_r                   <= WAKE;
            wake_src_r[WAKE_SRC_CORE] <= bus.i_wakeup_req;
            wake_src_r[NUM_WAKE:1]    <= bus.i_irq & bus.i_wake_mask;
          end else begin
            state_r <= SLEEP;
          end
        end
        WAKE: begin
          if (settle_zero_s) begin
            state_r    <= RUN;
            clk_en_r   <= 1'b1;
            sleep_r    <= 1'b0;
            wake_vld_r <= 1'b1;
          end else begin
            state_r <= WAKE;
          end
        end
        default: begin
          state_r  <= RUN;
          clk_en_r <= 1'b1;
          sleep_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_clk_en    = clk_en_r;
  assign bus.o_sleep     = sleep_r;
  assign bus.o_wake_src  = wake_src_r;
  assign bus.o_wake_vld  = wake_vld_r;
  assign bus.o_drain_err = drain_err_r;

`ifdef SERV_SLEEP_CTRL_STATS_EN
  logic [31:0] sleep_cycles_r;

  // Saturating count of cycles spent with the core clock gated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sleep_cycles_r <= 32'd0;
    end else if ((state_r == SLEEP || state_r == WAKE) && (sleep_cycles_r != 32'hFFFF_FFFF)) begin
      sleep_cycles_r <= sleep_cycles_r + 32'd1;
    end else begin
      sleep_cycles_r <= sleep_cycles_r;
    end
  end

  assign bus.o_sleep_cycles = sleep_cycles_r;
`else
  assign bus.o_sleep_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Directed bench for serv_sleep_ctrl with NUM_WAKE=2, SETTLE=2, DRAIN_MAX=4.
module tb_serv_sleep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serv_sleep_ctrl_if #(.NUM_WAKE(2)) bus ();

  serv_sleep_ctrl #(
    .NUM_WAKE  (2),
    .SETTLE    (2),
    .DRAIN_MAX (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic clk_en, input logic slp,
                         input logic vld, input logic err);
    chk({tag, ".clk_en"}, {31'd0, bus.o_clk_en}, {31'd0, clk_en});
    chk({tag, ".sleep"}, {31'd0, bus.o_sleep}, {31'd0, slp});
    chk({tag, ".wake_vld"}, {31'd0, bus.o_wake_vld}, {31'd0, vld});
    chk({tag, ".drain_err"}, {31'd0, bus.o_drain_err}, {31'd0, err});
  endtask

  initial begin
    bus.i_sleep_req  = 1'b0;
    bus.i_wakeup_req = 1'b0;
    bus.i_irq        = 2'b00;
    bus.i_wake_mask  = 2'b00;
    bus.i_bus_busy   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.wake_src", {29'd0, bus.o_wake_src}, 32'd0);
    chk("reset.cycles", bus.o_sleep_cycles, 32'd0);

    // Sleep entry with idle bus, then irq[1] wake with SETTLE=2.
    bus.i_sleep_req = 1'b1;
    tick();
    bus.i_sleep_req = 1'b0;
    chk_out("t1.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("t1.sleep", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.i_irq       = 2'b10;
    bus.i_wake_mask = 2'b11;
    tick();
    bus.i_irq = 2'b00;
    chk_out("t1.wake", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1.wake_src", {29'd0, bus.o_wake_src}, 32'h4);
    tick();
    chk_out("t1.settle1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("t1.settle0", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("t1.run", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1.src_hold", {29'd0, bus.o_wake_src}, 32'h4);
`ifdef SERV_SLEEP_CTRL_STATS_EN
    chk("t1.cycles", bus.o_sleep_cycles, 32'd4);
`else
    chk("t1.cycles", bus.o_sleep_cycles, 32'd0);
`endif
    tick();
    chk_out("t1.after", 1'b1, 1'b0, 1'b0, 1'b0);

    // Sleep and wake together: wake wins, clock never drops.
    bus.i_sleep_req  = 1'b1;
    bus.i_wakeup_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t2.both", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus.i_sleep_req  = 1'b0;
    bus.i_wakeup_req = 1'b0;
    tick();

    // Busy bus: drain timeout pulses 5 cycles after the request.
    bus.i_bus_busy  = 1'b1;
    bus.i_sleep_req = 1'b1;
    tick();
    bus.i_sleep_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk_out("t3.draining", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_out("t3.timeout", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t3.after", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.i_bus_busy = 1'b0;

    // Masked irq does not wake; unmasking it does.
    bus.i_wake_mask = 2'b00;
    bus.i_sleep_req = 1'b1;
    tick();
    bus.i_sleep_req = 1'b0;
    tick();
    chk_out("t4.sleep", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.i_irq = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t4.masked", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    bus.i_wake_mask = 2'b01;
    tick();
    bus.i_irq       = 2'b00;
    bus.i_wake_mask = 2'b00;
    chk("t4.wake_src", {29'd0, bus.o_wake_src}, 32'h2);
    tick();
    tick();
    chk_out("t4.settle", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("t4.run", 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while in WAKE.
    bus.i_sleep_req = 1'b1;
    tick();
    bus.i_sleep_req = 1'b0;
    tick();
    bus.i_wakeup_req = 1'b1;
    tick();
    bus.i_wakeup_req = 1'b0;
    chk("t5.wake_src", {29'd0, bus.o_wake_src}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("t5.reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5.src_clr", {29'd0, bus.o_wake_src}, 32'd0);
    chk("t5.cycles_clr", bus.o_sleep_cycles, 32'd0);
    tick();
    chk_out("t5.after", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
